vga_pattern_gen: RTL and testbench
==================================

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line; must be a multiple of 8.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, vertical sizes in lines.
REQ-004 SHALL have parameter CLK_DIV, default 4, clk cycles per pixel; legal values are 1 or more.
REQ-005 SHALL have parameter COLOR_W, default 4, bits per colour channel.
REQ-006 SHALL have parameter CHECK_LOG2, default 5, log2 of checkerboard cell size in pixels.
REQ-007 SHALL have parameter SYNC_POL, default 0; 0 means sync pulses are active-low, 1 means active-high.
REQ-008 SHALL have input clk, 1 bit: system clock; all logic is on the rising edge.
REQ-009 SHALL have input rstn, 1 bit: reset, synchronous, active-low.
REQ-010 SHALL have input mode, 2 bits: requested pattern; 0 solid, 1 colour bars, 2 checkerboard, 3 gradient.
REQ-011 SHALL have input solid_color, 3*COLOR_W bits: {R,G,B} colour used by modes 0 and 2.
REQ-012 SHALL have output hsync, 1 bit: horizontal sync.
REQ-013 SHALL have output vsync, 1 bit: vertical sync.
REQ-014 SHALL have output rgb, 3*COLOR_W bits: pixel colour {R,G,B}.
REQ-015 SHALL have output frame_start, 1 bit: one-clk pulse at the start of each frame.

Function
REQ-016 SHALL generate pix_tick, high for 1 clk every CLK_DIV clks, from a divider counter; when CLK_DIV=1, pix_tick is held high.
REQ-017 SHALL advance counter hcnt on pix_tick over 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, then wrap to 0.
REQ-018 SHALL increment vcnt when hcnt wraps, over 0..V_TOTAL-1, where V_TOTAL is the sum of the V_ parameters, then wrap to 0.
REQ-019 SHALL treat the raw pixel as active when hcnt<H_ACTIVE and vcnt<V_ACTIVE; x=hcnt and y=vcnt.
REQ-020 SHALL assert raw hsync for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and raw vsync on the analogous vcnt range.
REQ-021 SHALL register the pattern colour, the active flag and both syncs together on pix_tick, giving 1 pixel of latency with sync and colour aligned.
REQ-022 SHALL apply SYNC_POL at the output: the output level is the raw level XOR ~SYNC_POL.
REQ-023 SHALL drive rgb to 0 whenever the registered active flag is low (blanking).
REQ-024 SHALL latch mode into mode_q only on the pix_tick where hcnt=0 and vcnt=0; a mode change mid-frame takes effect on the next frame only.
REQ-025 SHALL pulse frame_start for exactly 1 clk on that same latch tick.
REQ-026 Mode 0 SHALL output solid_color.
REQ-027 Mode 1 SHALL compute bar index b = x/(H_ACTIVE/8), i.e. 8 vertical bars.
REQ-028 Mode 1 bar colours SHALL be, for b=0..7: white, yellow, cyan, green, magenta, red, blue, black, each channel all-ones or zero.
REQ-029 Mode 2 SHALL output solid_color when x[CHECK_LOG2]^y[CHECK_LOG2]=0, else 0.
REQ-030 Mode 3 SHALL set R = x[COLOR_W+1:2], G = y[COLOR_W+1:2], B = ~R, each truncated to COLOR_W bits.
REQ-031 SHALL sample solid_color every pixel; it is not frame-latched.
REQ-032 SHALL size counter widths with $clog2 of the totals; there SHALL be no overflow at wrap.

Reset
REQ-033 SHALL, while rstn=0 at a clk edge, clear the divider, hcnt, vcnt and mode_q (to 0), and clear the active register.
REQ-034 SHALL, during reset, force hsync and vsync to the inactive level, rgb=0 and frame_start=0.
REQ-035 SHALL, after reset is released mid-frame, restart at hcnt=vcnt=0; the first pix_tick after release produces frame_start and latches mode.

Verification
REQ-036 Defaults, mode=0, solid_color=12'hF0F -> 800 pixels per line, 525 lines per frame; hsync low for 96 pixels starting at pixel 656; vsync low on lines 490-491; rgb=F0F in the active area and 000 in blanking.
REQ-037 Mode=1 -> pixels 0-79 give FFF, 80-159 give FF0, and pixels 560-639 give 000, on every active line.
REQ-038 Mode=2, solid_color=12'h0F0 -> pixel (0,0) gives 0F0, (32,0) gives 000, (32,32) gives 0F0.
REQ-039 Change mode 0->1 at line 100 -> the rest of the frame stays solid; the next frame is bars; frame_start pulses once per 800*525*4 clks.
REQ-040 Assert rstn=0 for 3 clks at line 300 -> during reset syncs are inactive and rgb=000; after release hcnt and vcnt restart at 0 and frame_start pulses on the first pix_tick.
REQ-041 CLK_DIV=1, SYNC_POL=1 -> syncs are active-high; line period is 800 clks; rgb lags its raw pixel by 1 clk, the same delay as the syncs.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
//   Free-running VGA timing generator with four built-in test patterns.
//   A clock divider produces a pixel tick every CLK_DIV clocks. Horizontal and
//   vertical counters walk the full raster. Colour, active flag and both syncs
//   are registered together on the pixel tick, so all outputs carry the same
//   one-pixel latency.
//
// Ports
//   clk          system clock, rising edge
//   rstn         synchronous active-low reset
//   mode         requested pattern (0 solid, 1 bars, 2 checker, 3 gradient);
//                sampled only at the first pixel of a frame
//   solid_color  {R,G,B} used by solid and checkerboard, sampled every pixel
//   hsync/vsync  sync outputs, polarity set by SYNC_POL
//   rgb          pixel colour {R,G,B}, zero during blanking
//   frame_start  one-clock pulse when the first pixel of a frame is latched
// ---------------------------------------------------------------------------
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 4,
  parameter int COLOR_W    = 4,
  parameter int CHECK_LOG2 = 5,
  parameter int SYNC_POL   = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_color,
  output logic                 hsync,
  output logic                 vsync,
  output logic [3*COLOR_W-1:0] rgb,
  output logic                 frame_start
);

  typedef enum logic [1:0] {
    M_SOLID = 2'd0,
    M_BARS  = 2'd1,
    M_CHECK = 2'd2,
    M_GRAD  = 2'd3
  } mode_e;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   HS_FIRST = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [H_W-1:0]   BAR_W    = H_W'(H_ACTIVE / 8);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   VS_FIRST = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic             SYNC_HIGH = (SYNC_POL != 0);

  logic [DIV_W-1:0]   r_div;
  logic [H_W-1:0]     r_hcnt;
  logic [V_W-1:0]     r_vcnt;
  mode_e              r_mode;
  logic               r_hs;
  logic               r_vs;
  logic               r_active;
  logic [3*COLOR_W-1:0] r_rgb;
  logic               r_frame_start;

  logic               w_pix_tick;
  logic               w_origin;
  logic               w_active;
  logic               w_hs_raw;
  logic               w_vs_raw;
  mode_e              w_mode;
  logic [2:0]         w_bar;
  logic [2:0]         w_bar_rgb;
  logic [3*COLOR_W-1:0] w_color;

  // With CLK_DIV=1 the divider is a single bit pinned at 0, which equals
  // DIV_LAST, so the tick is permanently high without a special case.
  assign w_pix_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_div <= '0;
    end else if (w_pix_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_origin = (r_hcnt == '0) && (r_vcnt == '0);
  assign w_active = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_hs_raw = (r_hcnt >= HS_FIRST) && (r_hcnt <= HS_LAST);
  assign w_vs_raw = (r_vcnt >= VS_FIRST) && (r_vcnt <= VS_LAST);

  // The first pixel of a frame is rendered with the mode being latched on
  // that same tick, so the new mode covers the whole frame including (0,0).
  assign w_mode = w_origin ? mode_e'(mode) : r_mode;

  assign w_bar = 3'(r_hcnt / BAR_W);

  always_comb begin
    w_bar_rgb = 3'b000;
    case (w_bar)
      3'd0:    w_bar_rgb = 3'b111;  // white
      3'd1:    w_bar_rgb = 3'b110;  // yellow
      3'd2:    w_bar_rgb = 3'b011;  // cyan
      3'd3:    w_bar_rgb = 3'b010;  // green
      3'd4:    w_bar_rgb = 3'b101;  // magenta
      3'd5:    w_bar_rgb = 3'b100;  // red
      3'd6:    w_bar_rgb = 3'b001;  // blue
      default: w_bar_rgb = 3'b000;  // black
    endcase
  end

  always_comb begin
    w_color = '0;
    case (w_mode)
      M_SOLID: w_color = solid_color;
      M_BARS:  w_color = {{COLOR_W{w_bar_rgb[2]}},
                          {COLOR_W{w_bar_rgb[1]}},
                          {COLOR_W{w_bar_rgb[0]}}};
      M_CHECK: w_color = (r_hcnt[CHECK_LOG2] ^ r_vcnt[CHECK_LOG2]) ? '0 : solid_color;
      M_GRAD:  w_color = {r_hcnt[COLOR_W+1:2],
                          r_vcnt[COLOR_W+1:2],
                          ~r_hcnt[COLOR_W+1:2]};
      default: w_color = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_mode        <= M_SOLID;
      r_hs          <= 1'b0;
      r_vs          <= 1'b0;
      r_active      <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_pix_tick && w_origin;
      if (w_pix_tick) begin
        // Pipeline stage: everything describing the current raw pixel moves
        // into the output registers together.
        r_hs     <= w_hs_raw;
        r_vs     <= w_vs_raw;
        r_active <= w_active;
        r_rgb    <= w_color;
        if (w_origin) begin
          r_mode <= mode_e'(mode);
        end
        if (r_hcnt == H_LAST) begin
          r_hcnt <= '0;
          if (r_vcnt == V_LAST) begin
            r_vcnt <= '0;
          end else begin
            r_vcnt <= r_vcnt + 1'b1;
          end
        end else begin
          r_hcnt <= r_hcnt + 1'b1;
        end
      end
    end
  end

  assign hsync       = SYNC_HIGH ? r_hs : ~r_hs;
  assign vsync       = SYNC_HIGH ? r_vs : ~r_vs;
  assign rgb         = r_active ? r_rgb : '0;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen. Two instances share the inputs: one with
// CLK_DIV=2 and active-low syncs, one with CLK_DIV=1 and active-high syncs.
// A small raster keeps the frame short.
module tb_vga_pattern_gen;

  localparam int HA = 32, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 40, VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;   // 40
  localparam int VT = VA + VFP + VS + VBP;   // 46
  localparam int CL = 2;
  localparam int DA = 2;
  localparam int DB = 1;
  localparam int LIMIT = 2 * HT * VT * DA + 10;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        fs;
  } out_t;

  typedef struct {
    int          m;
    logic [11:0] sc;
    int          x;
    int          y;
    logic [11:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  mode;
  logic [11:0] solid;
  logic        a_hs, a_vs, a_fs, b_hs, b_vs, b_fs;
  logic [11:0] a_rgb, b_rgb;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(DA), .COLOR_W(4), .CHECK_LOG2(CL), .SYNC_POL(0)
  ) u_dut_a (
    .clk(clk), .rstn(rstn), .mode(mode), .solid_color(solid),
    .hsync(a_hs), .vsync(a_vs), .rgb(a_rgb), .frame_start(a_fs)
  );

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(DB), .COLOR_W(4), .CHECK_LOG2(CL), .SYNC_POL(1)
  ) u_dut_b (
    .clk(clk), .rstn(rstn), .mode(mode), .solid_color(solid),
    .hsync(b_hs), .vsync(b_vs), .rgb(b_rgb), .frame_start(b_fs)
  );

  // ---------------- reference model ----------------
  function automatic out_t reset_out(input bit pol);
    out_t o;
    o.hs = !pol; o.vs = !pol; o.rgb = '0; o.fs = 1'b0;
    return o;
  endfunction

  function automatic out_t ref_pixel(input int h, input int v, input int m,
                                     input logic [11:0] sc, input bit pol);
    out_t o;
    bit hr, vr;
    int r, g;
    hr = (h >= HA + HFP) && (h < HA + HFP + HS);
    vr = (v >= VA + VFP) && (v < VA + VFP + VS);
    o.hs = pol ? hr : !hr;
    o.vs = pol ? vr : !vr;
    o.fs = 1'b0;
    o.rgb = '0;
    if (h < HA && v < VA) begin
      case (m)
        0: o.rgb = sc;
        1: case (h / (HA / 8))
             0: o.rgb = 12'hFFF;
             1: o.rgb = 12'hFF0;
             2: o.rgb = 12'h0FF;
             3: o.rgb = 12'h0F0;
             4: o.rgb = 12'hF0F;
             5: o.rgb = 12'hF00;
             6: o.rgb = 12'h00F;
             default: o.rgb = 12'h000;
           endcase
        2: o.rgb = ((((h >> CL) ^ (v >> CL)) & 1) != 0) ? 12'h000 : sc;
        default: begin
          r = (h >> 2) % 16;
          g = (v >> 2) % 16;
          o.rgb = {4'(r), 4'(g), 4'(15 - r)};
        end
      endcase
    end
    return o;
  endfunction

  // e counts clock edges since reset release; every d-th edge a new pixel
  // (index e/d-1 in raster order) appears at the outputs.
  task automatic step(input int d, input bit pol, input int e_in, input int fm_in,
                      input out_t o_in, output int e_out, output int fm_out,
                      output out_t o_out);
    int p, h, v;
    fm_out = fm_in;
    if (!rstn) begin
      e_out = 0;
      o_out = reset_out(pol);
    end else begin
      e_out = e_in + 1;
      o_out = o_in;
      o_out.fs = 1'b0;
      if (e_out % d == 0) begin
        p = e_out / d - 1;
        h = p % HT;
        v = (p / HT) % VT;
        if (h == 0 && v == 0) fm_out = int'(mode);
        o_out = ref_pixel(h, v, fm_out, solid, pol);
        o_out.fs = (h == 0 && v == 0);
      end
    end
  endtask

  int   e_a, e_b, fm_a, fm_b;
  out_t exp_a, exp_b;

  initial begin
    e_a = 0; e_b = 0; fm_a = 0; fm_b = 0;
    exp_a = reset_out(1'b0);
    exp_b = reset_out(1'b1);
    forever begin
      @(posedge clk);
      step(DA, 1'b0, e_a, fm_a, exp_a, e_a, fm_a, exp_a);
      step(DB, 1'b1, e_b, fm_b, exp_b, e_b, fm_b, exp_b);
    end
  end

  // Continuous comparison of both instances against the model.
  initial begin
    out_t got;
    @(posedge clk);
    forever begin
      @(negedge clk);
      got = {a_hs, a_vs, a_rgb, a_fs};
      vec_cnt++;
      if (got !== exp_a) begin
        err_cnt++;
        $display("FAIL model_a t=%0t got hs=%b vs=%b rgb=%h fs=%b exp hs=%b vs=%b rgb=%h fs=%b",
                 $time, got.hs, got.vs, got.rgb, got.fs, exp_a.hs, exp_a.vs, exp_a.rgb, exp_a.fs);
      end
      got = {b_hs, b_vs, b_rgb, b_fs};
      vec_cnt++;
      if (got !== exp_b) begin
        err_cnt++;
        $display("FAIL model_b t=%0t got hs=%b vs=%b rgb=%h fs=%b exp hs=%b vs=%b rgb=%h fs=%b",
                 $time, got.hs, got.vs, got.rgb, got.fs, exp_b.hs, exp_b.vs, exp_b.rgb, exp_b.fs);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_fs && n < LIMIT);
    if (!a_fs) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL wait_fs got no frame_start after %0d clks exp a pulse", n);
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[26];

  initial begin
    int cur, cm, tgt, n, w, total;
    logic prev;

    tbl[0]  = '{1, 12'h000,  0,  0, 12'hFFF};
    tbl[1]  = '{1, 12'h000,  3,  5, 12'hFFF};
    tbl[2]  = '{1, 12'h000,  4,  5, 12'hFF0};
    tbl[3]  = '{1, 12'h000,  8,  5, 12'h0FF};
    tbl[4]  = '{1, 12'h000, 12,  5, 12'h0F0};
    tbl[5]  = '{1, 12'h000, 16,  5, 12'hF0F};
    tbl[6]  = '{1, 12'h000, 20,  5, 12'hF00};
    tbl[7]  = '{1, 12'h000, 24,  5, 12'h00F};
    tbl[8]  = '{1, 12'h000, 28,  5, 12'h000};
    tbl[9]  = '{1, 12'h000, 31, 39, 12'h000};
    tbl[10] = '{2, 12'h0F0,  0,  0, 12'h0F0};
    tbl[11] = '{2, 12'h0F0,  4,  0, 12'h000};
    tbl[12] = '{2, 12'h0F0,  0,  4, 12'h000};
    tbl[13] = '{2, 12'h0F0,  4,  4, 12'h0F0};
    tbl[14] = '{2, 12'h0F0,  5,  9, 12'h000};
    tbl[15] = '{2, 12'h0F0,  9,  9, 12'h0F0};
    tbl[16] = '{2, 12'h123, 12, 12, 12'h123};
    tbl[17] = '{0, 12'hF0F, 10, 10, 12'hF0F};
    tbl[18] = '{0, 12'h5A3, 11, 10, 12'h5A3};
    tbl[19] = '{0, 12'h5A3, 33, 10, 12'h000};
    tbl[20] = '{0, 12'h5A3,  5, 41, 12'h000};
    tbl[21] = '{3, 12'h000,  3,  3, 12'h00F};
    tbl[22] = '{3, 12'h000, 20, 37, 12'h59A};
    tbl[23] = '{3, 12'h000, 31, 39, 12'h798};
    tbl[24] = '{3, 12'h000, 36, 20, 12'h000};
    tbl[25] = '{3, 12'h000, 10, 44, 12'h000};

    rstn = 1'b0; mode = 2'd0; solid = 12'hF0F;
    repeat (3) @(negedge clk);
    check("reset_a", {1'b0, reset_out(1'b0)}, {1'b0, a_hs, a_vs, a_rgb, a_fs});
    check("reset_b", {1'b0, b_hs, b_vs, b_rgb, b_fs}, {1'b0, reset_out(1'b1)});
    rstn = 1'b1;

    // Table-driven pixel spot checks on instance A.
    cur = 0; cm = -1;
    for (int i = 0; i < 26; i++) begin
      tgt = tbl[i].y * HT + tbl[i].x;
      solid = tbl[i].sc;
      if (tbl[i].m != cm || tgt <= cur) begin
        mode = 2'(tbl[i].m);
        cm = tbl[i].m;
        wait_fs(n);
        cur = 0;
      end
      repeat ((tgt - cur) * DA) @(negedge clk);
      cur = tgt;
      check($sformatf("tbl%0d_m%0d_x%0d_y%0d", i, tbl[i].m, tbl[i].x, tbl[i].y),
            {4'h0, a_rgb}, {4'h0, tbl[i].exp});
    end

    // Mode change mid-frame takes effect only on the next frame.
    mode = 2'd0; solid = 12'hF0F;
    wait_fs(n);
    repeat (10 * HT * DA) @(negedge clk);
    mode = 2'd1;
    repeat ((10 * HT + 8) * DA) @(negedge clk);
    check("midframe_hold", {4'h0, a_rgb}, 16'h0F0F);
    total = (20 * HT + 8) * DA;
    wait_fs(n);
    total += n;
    check("frame_period", 16'(total), 16'(HT * VT * DA));
    repeat ((5 * HT + 8) * DA) @(negedge clk);
    check("next_frame_bars", {4'h0, a_rgb}, 16'h00FF);

    // Sync pulse widths: A low for HS pixels, B active-high line period.
    w = 0;
    do begin @(negedge clk); w++; end while (a_hs && w < LIMIT);
    n = 0;
    while (!a_hs && n < LIMIT) begin @(negedge clk); n++; end
    check("a_hsync_low_width", 16'(n), 16'(HS * DA));
    w = 0;
    do begin @(negedge clk); w++; end while (b_hs && w < LIMIT);
    do begin @(negedge clk); w++; end while (!b_hs && w < LIMIT);
    n = 0; prev = b_hs;
    do begin
      @(negedge clk);
      n++;
      if (b_hs && !prev) break;
      prev = b_hs;
    end while (n < LIMIT);
    check("b_hsync_period", 16'(n), 16'(HT * DB));

    // Reset held for 3 clocks in the middle of line 30.
    mode = 2'd0;
    wait_fs(n);
    repeat (30 * HT * DA + 5) @(negedge clk);
    mode = 2'd3;
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("inreset_a_%0d", k), {1'b0, a_hs, a_vs, a_rgb, a_fs}, {1'b0, reset_out(1'b0)});
      check($sformatf("inreset_b_%0d", k), {1'b0, b_hs, b_vs, b_rgb, b_fs}, {1'b0, reset_out(1'b1)});
    end
    rstn = 1'b1;
    wait_fs(n);
    check("restart_fs_latency", 16'(n), 16'(DA));
    check("restart_first_pixel", {4'h0, a_rgb}, 16'h000F);

    // Randomised mode / colour changes at random times.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(20, 300)) @(negedge clk);
      mode = 2'($urandom_range(0, 3));
      solid = 12'($urandom);
    end
    repeat (HT * 3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
